// File: rtl/mux_n_1_reg.sv
// mux_n_1_reg: NCH-channel, WIDTH-bit valid/ready selector feeding a single-entry output register.
// Define MUX_RR_ARB_EN to add the rr_mode port and round-robin arbitration over the channels.
module mux_n_1_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
`ifdef MUX_RR_ARB_EN
  input  logic                 rr_mode,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SELW:0] NCH_W    = (SELW+1)'(NCH);
  localparam logic          ST_EMPTY = 1'b0;
  localparam logic          ST_FULL  = 1'b1;

  logic             r_state;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;

  logic             w_space;
  logic             w_grant_ok;
  logic [SELW-1:0]  w_grant;
  logic [WIDTH-1:0] w_gdata;
  logic             w_gvalid;
  logic             w_accept;

  // rst_n gating keeps every in_ready low while the block is held in reset
  assign w_space  = rst_n & ((r_state == ST_EMPTY) | out_ready);
  assign w_accept = w_space & w_grant_ok & w_gvalid;

`ifdef MUX_RR_ARB_EN
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH-1);

  logic [SELW-1:0] r_rr_ptr;
  logic            w_hi_found;
  logic [SELW-1:0] w_hi_grant;
  logic            w_lo_found;
  logic [SELW-1:0] w_lo_grant;

  // Lowest valid channel at or above rr_ptr, else lowest valid channel overall (wrap)
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_grant = {SELW{1'b0}};
    w_lo_found = 1'b0;
    w_lo_grant = {SELW{1'b0}};
    for (int i = NCH-1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_grant = SELW'(i);
        if (SELW'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_grant = SELW'(i);
        end else begin
          w_hi_found = w_hi_found;
        end
      end else begin
        w_lo_found = w_lo_found;
      end
    end
  end

  // Grant selection: round-robin scan or external select
  always_comb begin
    w_grant    = sel;
    w_grant_ok = ({1'b0, sel} < NCH_W);
    if (rr_mode) begin
      w_grant    = w_hi_found ? w_hi_grant : w_lo_grant;
      w_grant_ok = w_lo_found;
    end else begin
      w_grant    = sel;
      w_grant_ok = ({1'b0, sel} < NCH_W);
    end
  end

  // Round-robin pointer moves past the granted channel on each round-robin accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= {SELW{1'b0}};
    end else if (rr_mode && w_accept) begin
      r_rr_ptr <= (w_grant == LAST_CH) ? {SELW{1'b0}} : (w_grant + SELW'(1));
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`else
  // Fixed-select grant; out-of-range selects grant nothing
  always_comb begin
    w_grant    = sel;
    w_grant_ok = ({1'b0, sel} < NCH_W);
  end
`endif

  // Granted channel's data and valid
  always_comb begin
    w_gdata  = {WIDTH{1'b0}};
    w_gvalid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == SELW'(i)) begin
        w_gdata  = in_data[i*WIDTH +: WIDTH];
        w_gvalid = in_valid[i];
      end else begin
        w_gvalid = w_gvalid;
      end
    end
  end

  // One-hot ready toward the granted channel, independent of in_valid in fixed mode
  always_comb begin
    in_ready = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = w_space & w_grant_ok & (w_grant == SELW'(i));
    end
  end

  // EMPTY/FULL occupancy of the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: r_state <= w_accept ? ST_FULL : ST_EMPTY;
        ST_FULL: begin
          if (w_accept) begin
            r_state <= ST_FULL;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end else begin
            r_state <= ST_FULL;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Output word and source id; held whenever nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {WIDTH{1'b0}};
      r_chan <= {SELW{1'b0}};
    end else if (w_accept) begin
      r_data <= w_gdata;
      r_chan <= w_grant;
    end else begin
      r_data <= r_data;
      r_chan <= r_chan;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Bench for mux_n_1_reg (NCH=4, SELW=3 so out-of-range selects can be driven).
// Directed vector table, async-reset and round-robin sequences, then random traffic against a reference model.
module tb_mux_n_1_reg;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [SELW-1:0]  sel;
  logic             rr_mode;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0]  out_chan;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ch [NCH];

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_chan;
  int               m_ptr;

  always #5 clk = ~clk;

  assign in_data = {ch[3], ch[2], ch[1], ch[0]};

  mux_n_1_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
`ifdef MUX_RR_ARB_EN
    .rr_mode   (rr_mode),
`endif
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [2:0]  sel;
    logic        ordy;
    logic [31:0] d2;
    logic [3:0]  rdy;
    logic        ov;
    logic [2:0]  oc;
    logic [31:0] od;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'hf;
    sel       = 3'd0;
    out_ready = 1'b1;
    rr_mode   = 1'b0;
    ch[0] = 32'haaaa0000; ch[1] = 32'hbbbb1111; ch[2] = 32'hcccc2222; ch[3] = 32'hdddd3333;
    #1;
    chk("reset in_ready", {60'd0, in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    in_valid = 4'h0;
    m_valid = 1'b0; m_data = 32'd0; m_chan = 0; m_ptr = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0]  = '{4'b0011, 3'd0, 1'b1, 32'hcccc2222, 4'b0001, 1'b1, 3'd0, 32'haaaa0000};
    vt[1]  = '{4'b0011, 3'd1, 1'b1, 32'hcccc2222, 4'b0010, 1'b1, 3'd1, 32'hbbbb1111};
    vt[2]  = '{4'b0100, 3'd2, 1'b1, 32'hc0000001, 4'b0100, 1'b1, 3'd2, 32'hc0000001};
    vt[3]  = '{4'b0100, 3'd2, 1'b1, 32'hc0000002, 4'b0100, 1'b1, 3'd2, 32'hc0000002};
    vt[4]  = '{4'b0100, 3'd2, 1'b1, 32'hc0000003, 4'b0100, 1'b1, 3'd2, 32'hc0000003};
    vt[5]  = '{4'b0000, 3'd2, 1'b0, 32'hc0000003, 4'b0000, 1'b1, 3'd2, 32'hc0000003};
    vt[6]  = '{4'b0100, 3'd2, 1'b0, 32'hdead0000, 4'b0000, 1'b1, 3'd2, 32'hc0000003};
    vt[7]  = '{4'b0100, 3'd2, 1'b0, 32'hdead0001, 4'b0000, 1'b1, 3'd2, 32'hc0000003};
    vt[8]  = '{4'b0100, 3'd2, 1'b0, 32'hdead0002, 4'b0000, 1'b1, 3'd2, 32'hc0000003};
    vt[9]  = '{4'b0100, 3'd2, 1'b0, 32'hdead0003, 4'b0000, 1'b1, 3'd2, 32'hc0000003};
    vt[10] = '{4'b0100, 3'd2, 1'b1, 32'hc0000004, 4'b0100, 1'b1, 3'd2, 32'hc0000004};
    vt[11] = '{4'b1111, 3'd5, 1'b1, 32'hc0000005, 4'b0000, 1'b0, 3'd2, 32'hc0000004};
    vt[12] = '{4'b1111, 3'd5, 1'b1, 32'hc0000006, 4'b0000, 1'b0, 3'd2, 32'hc0000004};
    vt[13] = '{4'b1000, 3'd3, 1'b0, 32'hcccc2222, 4'b1000, 1'b1, 3'd3, 32'hdddd3333};
    vt[14] = '{4'b0000, 3'd3, 1'b1, 32'hcccc2222, 4'b1000, 1'b0, 3'd3, 32'hdddd3333};

    do_reset();
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_data", {32'd0, out_data}, 64'd0);
    chk("reset out_chan", {61'd0, out_chan}, 64'd0);

    for (int r = 0; r < 15; r++) begin
      in_valid  = vt[r].vld;
      sel       = vt[r].sel;
      out_ready = vt[r].ordy;
      ch[2]     = vt[r].d2;
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", r), {60'd0, in_ready}, {60'd0, vt[r].rdy});
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", r), {63'd0, out_valid}, {63'd0, vt[r].ov});
      chk($sformatf("vec%0d out_chan", r), {61'd0, out_chan}, {61'd0, vt[r].oc});
      chk($sformatf("vec%0d out_data", r), {32'd0, out_data}, {32'd0, vt[r].od});
    end

    // asynchronous reset while a word is held
    ch[2] = 32'hcccc2222;
    in_valid = 4'b0001; sel = 3'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset out_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("async rst out_data", {32'd0, out_data}, 64'd0);
    chk("async rst out_chan", {61'd0, out_chan}, 64'd0);
    chk("async rst in_ready", {60'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rst held out_valid", {63'd0, out_valid}, 64'd0);
    do_reset();

`ifdef MUX_RR_ARB_EN
    begin
      int exp_rr [8];
      exp_rr = '{0, 1, 2, 3, 0, 3, 3, 3};
      rr_mode = 1'b1; out_ready = 1'b1; sel = 3'd2; in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
        if (k == 5) in_valid = 4'b1000;
        @(posedge clk); #1;
        chk($sformatf("rr%0d out_chan", k), {61'd0, out_chan}, 64'(exp_rr[k]));
        chk($sformatf("rr%0d out_data", k), {32'd0, out_data}, {32'd0, ch[exp_rr[k]]});
      end
      rr_mode = 1'b0;
      do_reset();
    end
`endif

    // random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic       is_rr;
      logic       space;
      logic       ok;
      int         g;
      logic [3:0] exp_rdy;
      in_valid  = 4'($urandom);
      sel       = 3'($urandom_range(0, 5));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NCH; i++) ch[i] = $urandom;
`ifdef MUX_RR_ARB_EN
      rr_mode = 1'($urandom_range(0, 1));
      is_rr   = rr_mode;
`else
      is_rr   = 1'b0;
`endif
      @(negedge clk);
      space = !m_valid || out_ready;
      g  = 0;
      ok = 1'b0;
      if (is_rr) begin
        for (int k = NCH-1; k >= 0; k--) begin
          if (in_valid[(m_ptr + k) % NCH]) begin
            g  = (m_ptr + k) % NCH;
            ok = 1'b1;
          end
        end
      end else begin
        g  = int'(sel);
        ok = (g < NCH);
      end
      exp_rdy = (space && ok) ? 4'(1 << g) : 4'd0;
      chk($sformatf("rand%0d in_ready", c), {60'd0, in_ready}, {60'd0, exp_rdy});
      chk($sformatf("rand%0d output", c), {28'd0, out_valid, out_chan, out_data},
          {28'd0, m_valid, 3'(m_chan), m_data});
      if (space && ok && in_valid[g]) begin
        m_valid = 1'b1;
        m_data  = ch[g];
        m_chan  = g;
        if (is_rr) m_ptr = (g + 1) % NCH;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
